serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit ripple adder. It is the addition counterpart of the team's full subtractor.
- One full-adder cell plus a carry flip-flop process one operand bit per clock, LSB first.
- Operands load on a start pulse. The result is presented with a one-cycle done pulse.
- Used where area matters more than latency, e.g. accumulators in slow control datapaths.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)
CNT_W, $clog2(WIDTH), bit counter width (derived, not overridden)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when state is IDLE or DONE
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse; sum/cout valid from this cycle on
sum  output  WIDTH  registered result, held until the next completion
cout  output  1  registered carry-out, held with sum

Behaviour:
- Reset (async, rst=1) clears the following:
  - state becomes IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Shift registers, counter and carry flop become 0.
  - Reset wins over any other event.
- FSM states are IDLE, RUN and DONE.
- IDLE, with start=1 at edge k:
  - Load sa<=a, sb<=b, c<=cin, cnt<=0.
  - Go to RUN.
  - With start=0, stay in IDLE.
- RUN, each edge:
  - Bit cell: s = sa[0]^sb[0]^c; co = sa[0]&sb[0] | c&(sa[0]^sb[0]).
  - Shift sa, sb right by 1.
  - Shift s into a result shift register from the MSB.
  - c <= co, cnt <= cnt+1.
- RUN completion, when cnt==WIDTH-1 on that edge:
  - Register the final sum as {s, shift[WIDTH-1:1]} and cout as co.
  - Go to DONE.
- DONE lasts exactly one cycle with done=1.
  - start=1: accept new operands exactly as from IDLE and go to RUN (back-to-back issue).
  - start=0: go to IDLE.
- Latency: start accepted at edge k gives done=1 in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- start while RUN is ignored. The in-flight operation and its operands are unaffected.
- a, b and cin are only sampled on an accepted start. Changes at any other time have no effect.
- sum/cout change only on the RUN-to-DONE transition. During RUN the previous result stays visible.
- Width rule: the result is WIDTH bits plus cout. The full value {cout,sum} = a+b+cin, exact and without overflow loss.
- Reset during RUN aborts the operation:
  - No done is generated.
  - sum/cout return to 0.
  - After rst deasserts, the next start behaves normally.

Decomposition:
- Shared package (arith_pkg) holds:
  - The state typedef, enum {IDLE, RUN, DONE}, 2 bits.
  - The default width constant, DEF_WIDTH=8.
- One natural sub-module, full_adder_bit. It is a purely combinational single-bit cell (a, b, cin -> sum, cout) instantiated once in the datapath. It is the adder twin of the subtractor cell.
- Counter, shift registers and FSM stay in serial_adder.

Test Plan:
- Basic add: a=0x5A, b=0x3C, cin=0, start 1 cycle.
  - busy for 8 cycles, then done pulse.
  - sum=0x96, cout=0.
- Carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start while busy: issue 0x10+0x20.
  - Mid-RUN, pulse start with a=0xAA, b=0x55.
  - Required: single done, sum=0x30, cout=0.
  - Second request dropped; state IDLE afterwards.
- Back-to-back: hold start=1 with 0x01+0x02, then 0x7F+0x01 presented in the DONE cycle.
  - done pulses 9 cycles apart.
  - Results 0x03 then 0x80, cout=0 both.
- Reset mid-operation: start 0xF0+0x0F, assert rst asynchronously at bit 4.
  - Immediately: busy=0, sum=0, cout=0, and no done is generated.
  - After release, 0x01+0x01 gives sum=0x02.
- Latency/hold: random 200-pair sweep against a+b+cin reference.
  - done exactly WIDTH+1 cycles after start edge.
  - sum/cout stable from done until the next completion.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-block definitions: FSM state encoding and default operand width.
package arith_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned STATE_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a serial adder and its user.
interface serial_adder_if #(
    parameter int unsigned WIDTH = arith_pkg::DEF_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/full_adder_bit.sv
// Single-bit combinational full-adder cell; the adder twin of the subtractor cell.
module full_adder_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    logic p;

    assign p      = a_i ^ b_i;
    assign sum_o  = p ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell and a carry flop, one operand bit per clock, LSB first.
module serial_adder
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);

    localparam int unsigned CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_co;

    full_adder_bit u_fa (
        .a_i    (sa_q[0]),
        .b_i    (sb_q[0]),
        .cin_i  (c_q),
        .sum_o  (fa_s),
        .cout_o (fa_co)
    );

    // Next-state and datapath; start is only honoured from IDLE or DONE.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        shift_d = shift_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    c_d     = bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                shift_d = WIDTH'({fa_s, shift_q} >> 1);
                c_d     = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = shift_d;
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            shift_q <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            shift_q <= shift_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: expected results queued at issue, compared on done.
module tb_serial_adder;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] held_sum = '0;
    logic         held_cout = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_if #(.WIDTH(W)) sif ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Output monitor: compares on done, checks hold between completions, flags late/spurious done.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            held_sum  = '0;
            held_cout = 1'b0;
        end else if (sif.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(1), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum", 32'(sif.sum), 32'(e.sum));
                check("cout", 32'(sif.cout), 32'(e.cout));
                check("latency", 32'(cyc), 32'(e.due));
                held_sum  = e.sum;
                held_cout = e.cout;
            end
        end else begin
            check("sum_hold", 32'(sif.sum), 32'(held_sum));
            check("cout_hold", 32'(sif.cout), 32'(held_cout));
            if (sb.size() != 0 && cyc > sb[0].due) begin
                check("done_timeout", 32'(cyc), 32'(sb[0].due));
                void'(sb.pop_front());
            end
        end
    end

    // Called at a negedge; start is accepted on the following rising edge.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                         input int mid_j, input bit hold, input bit chk_busy);
        logic [W:0] full;
        exp_t       e;
        full   = {1'b0, av} + {1'b0, bv} + (W+1)'(ci);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.due  = cyc + 1 + int'(W);
        sb.push_back(e);
        sif.start = 1'b1;
        sif.a     = av;
        sif.b     = bv;
        sif.cin   = ci;
        for (int j = 0; j <= int'(W); j++) begin
            @(negedge clk);
            if (j == 0) begin
                if (!hold) sif.start = 1'b0;
                sif.a   = W'($urandom);
                sif.b   = W'($urandom);
                sif.cin = 1'($urandom);
            end
            if (j == mid_j) begin
                sif.start = 1'b1;
                sif.a     = 8'hAA;
                sif.b     = 8'h55;
            end
            if (j == mid_j + 1) sif.start = hold;
            if (chk_busy) check("busy", 32'(sif.busy), 32'(j < int'(W)));
        end
        sif.start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        int           mid, gap;
        bit           hold;

        rst       = 1'b1;
        sif.start = 1'b0;
        sif.a     = '0;
        sif.b     = '0;
        sif.cin   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(sif.busy), 32'(0));
        check("rst_done", 32'(sif.done), 32'(0));
        check("rst_sum", 32'(sif.sum), 32'(0));
        check("rst_cout", 32'(sif.cout), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // Basic add with busy profile
        issue(8'h5A, 8'h3C, 1'b0, -1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);

        // Carry ripple
        issue(8'hFF, 8'h01, 1'b0, -1, 1'b0, 1'b0);
        @(negedge clk);
        issue(8'hFF, 8'hFF, 1'b1, -1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Start while busy is dropped
        issue(8'h10, 8'h20, 1'b0, 3, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(sif.busy), 32'(0));
        check("idle_done", 32'(sif.done), 32'(0));

        // Back-to-back with start held
        issue(8'h01, 8'h02, 1'b0, -1, 1'b1, 1'b0);
        issue(8'h7F, 8'h01, 1'b0, -1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);

        // Reset mid-operation aborts without done
        sif.start = 1'b1;
        sif.a     = 8'hF0;
        sif.b     = 8'h0F;
        sif.cin   = 1'b0;
        @(negedge clk);
        sif.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(sif.busy), 32'(0));
        check("abort_done", 32'(sif.done), 32'(0));
        check("abort_sum", 32'(sif.sum), 32'(0));
        check("abort_cout", 32'(sif.cout), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        issue(8'h01, 8'h01, 1'b0, -1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Random sweep with mixed gaps, held start and ignored mid-run requests
        for (int i = 0; i < 200; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rc   = 1'($urandom);
            mid  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : -1;
            hold = 1'($urandom_range(0, 1));
            issue(ra, rb, rc, mid, hold, 1'b0);
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
        end

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) check("drain", 32'(sb.size()), 32'(0));
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
